mul_share_arb: RTL

- Controller that shares the single 33x33 signed multiplier array between two requesters:
  - Requester 0 is the integer M-extension unit (MUL/MULH/MULHSU/MULHU).
  - Requester 1 is the FPU mantissa multiply path, which supplies the 48-bit mantissa product to fpu_mult.
- Sits in the EX stage next to the FPU.
- Arbitrates round-robin, latches operands, sequences the fixed-latency multiplier, and returns the product to the winning requester over a valid/ready handshake.

---
 rtl/mul_share_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mul_share_arb.sv
// Round-robin arbiter that time-shares one 33x33 signed multiplier between the
// integer M-extension unit (requester 0) and the FPU mantissa path (requester 1).
module mul_share_arb #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_a_signed,
    input  logic        req0_b_signed,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] req1_a,
    input  logic [23:0] req1_b,
    output logic [32:0] mul_a,
    output logic [32:0] mul_b,
    input  logic [65:0] mul_p,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [47:0] rsp1_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        last_r;
    logic        gid_r;
    logic [3:0]  cnt_r;
    logic [32:0] a_r;
    logic [32:0] b_r;
    logic [63:0] res_r;
    logic        win_s;
    logic        acc_s;
    logic        cnt_last_s;
    logic        rsp_hs_s;
    logic [32:0] a_s;
    logic [32:0] b_s;
    logic        unused_s;

    function automatic logic [32:0] ext33(input logic [31:0] x, input logic sgn);
        ext33 = {sgn & x[31], x};
    endfunction

    // Winner selection: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        win_s = 1'b0;
        if (req0_valid && req1_valid) begin
            win_s = ~last_r;
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    assign req0_ready = (state_r == IDLE) && req0_valid && !win_s;
    assign req1_ready = (state_r == IDLE) && req1_valid && win_s;
    assign acc_s      = req0_ready || req1_ready;
    assign a_s        = win_s ? {9'd0, req1_a} : ext33(req0_a, req0_a_signed);
    assign b_s        = win_s ? {9'd0, req1_b} : ext33(req0_b, req0_b_signed);
    assign cnt_last_s = (cnt_r == 4'(LAT - 1));
    assign rsp_hs_s   = (state_r == DONE) && (gid_r ? rsp1_ready : rsp0_ready);
    assign unused_s   = ^mul_p[65:64];

    // Next-state logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (rsp_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, grant pointer, latency counter, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            gid_r   <= 1'b0;
            cnt_r   <= 4'd0;
            a_r     <= 33'd0;
            b_r     <= 33'd0;
            res_r   <= 64'd0;
        end else begin
            state_r <= state_s;
            if (acc_s) begin
                a_r    <= a_s;
                b_r    <= b_s;
                gid_r  <= win_s;
                last_r <= win_s;
                cnt_r  <= 4'd0;
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r + 4'd1;
            end
            // The product is only trusted on the last RUN cycle.
            if ((state_r == RUN) && cnt_last_s) begin
                res_r <= mul_p[63:0];
            end
        end
    end

    assign mul_a      = a_r;
    assign mul_b      = b_r;
    assign rsp0_valid = (state_r == DONE) && !gid_r;
    assign rsp1_valid = (state_r == DONE) && gid_r;
    assign rsp0_data  = res_r;
    assign rsp1_data  = res_r[47:0];
    assign busy       = (state_r != IDLE);

endmodule
